// File: rtl/shift_register_sequencer.sv
// Command sequencer for a universal shift register: loads a word, shifts it out WIDTH times
// and rebuilds the serial stream into capturedWord, pulsing done on completion.
module shift_register_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic             clockPulse,
   input  logic             Reset,
   input  logic             startRequest,
   input  logic             direction,
   input  logic             fillBit,
   input  logic [WIDTH-1:0] loadWord,
   input  logic             abort,
   input  logic             ShiftOutput,
   output logic             ready,
   output logic             ParallelLoad,
   output logic             ShiftLeft,
   output logic             ShiftRight,
   output logic             ShiftInput,
   output logic [WIDTH-1:0] Data,
   output logic [WIDTH-1:0] capturedWord,
   output logic             done
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} stateT;

   localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

   stateT            stateQ, stateD;
   logic [WIDTH-1:0] wordQ, wordD;
   logic [WIDTH-1:0] captureQ, captureD;
   logic [WIDTH-1:0] capturedQ, capturedD;
   logic [WIDTH-1:0] captureNext;
   logic [CNT_W-1:0] countQ, countD;
   logic             dirQ, dirD;
   logic             fillQ, fillD;

   always_ff @(posedge clockPulse or posedge Reset) begin
      if (Reset) begin
         stateQ    <= StIdle;
         wordQ     <= '0;
         captureQ  <= '0;
         capturedQ <= '0;
         countQ    <= '0;
         dirQ      <= 1'b0;
         fillQ     <= 1'b0;
      end else begin
         stateQ    <= stateD;
         wordQ     <= wordD;
         captureQ  <= captureD;
         capturedQ <= capturedD;
         countQ    <= countD;
         dirQ      <= dirD;
         fillQ     <= fillD;
      end
   end

   // Left shifts emit the MSB first, so new bits enter at the LSB end; right shifts mirror that.
   always_comb begin
      if (dirQ) begin
         captureNext = {ShiftOutput, captureQ[WIDTH-1:1]};
      end else begin
         captureNext = {captureQ[WIDTH-2:0], ShiftOutput};
      end
   end

   always_comb begin
      stateD    = stateQ;
      wordD     = wordQ;
      captureD  = captureQ;
      capturedD = capturedQ;
      countD    = countQ;
      dirD      = dirQ;
      fillD     = fillQ;

      unique case (stateQ)
         StIdle: begin
            if (startRequest) begin
               wordD  = loadWord;
               dirD   = direction;
               fillD  = fillBit;
               stateD = StLoad;
            end
         end
         StLoad: begin
            captureD = '0;
            countD   = '0;
            stateD   = abort ? StIdle : StShift;
         end
         StShift: begin
            if (abort) begin
               captureD = '0;
               stateD   = StIdle;
            end else begin
               captureD = captureNext;
               countD   = countQ + 1'b1;
               if (countQ == LastCount) begin
                  capturedD = captureNext;
                  stateD    = StDone;
               end
            end
         end
         StDone: begin
            stateD = StIdle;
         end
         default: begin
            stateD = StIdle;
         end
      endcase
   end

   // Every output is decoded from registered state only.
   assign ready        = (stateQ == StIdle);
   assign ParallelLoad = (stateQ == StLoad);
   assign ShiftLeft    = (stateQ == StShift) && !dirQ;
   assign ShiftRight   = (stateQ == StShift) && dirQ;
   assign ShiftInput   = (stateQ == StShift) && fillQ;
   assign done         = (stateQ == StDone);
   assign Data         = wordQ;
   assign capturedWord = capturedQ;

endmodule

// File: doc/shift_register_sequencer.md
Name: shift_register_sequencer

Overview:
- Upstream command sequencer for the 4-bit universal shift register.
- Accepts a word through a ready/start handshake, then drives the register's ParallelLoad, ShiftLeft/ShiftRight and ShiftInput controls: one load cycle, then WIDTH shift cycles.
- Samples the register's ShiftOutput serial stream back into a captured word and pulses done.
- Used to serialise words through the register and to self-check it by round trip.

Parameters:
- WIDTH, 4, register/data width in bits.
- CNT_W, 3, shift-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clockPulse  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- startRequest  input  1  request to start a transfer; accepted only when ready=1.
- direction  input  1  0 = shift left (MSB exits first), 1 = shift right (LSB exits first); latched at accept.
- fillBit  input  1  serial fill value for the register; latched at accept.
- loadWord  input  WIDTH  word to load; latched at accept.
- abort  input  1  cancels an in-progress transfer.
- ShiftOutput  input  1  serial bit presented by the register during the current cycle.
- ready  output  1  sequencer idle, can accept a start.
- ParallelLoad  output  1  load command to the register.
- ShiftLeft  output  1  shift-left command.
- ShiftRight  output  1  shift-right command.
- ShiftInput  output  1  serial fill bit to the register.
- Data  output  WIDTH  parallel load data to the register.
- capturedWord  output  WIDTH  word rebuilt from ShiftOutput.
- done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- Reset (async, immediate) sets:
  - state = IDLE, ready = 1;
  - ParallelLoad, ShiftLeft, ShiftRight, ShiftInput, done = 0;
  - Data = 0, capturedWord = 0, internal count and capture register = 0.
- Reset asserted mid-transfer forces these values immediately, without waiting for a clock edge.
- State IDLE:
  - ready = 1, all commands 0, Data holds its last value.
  - At an edge with startRequest = 1: latch loadWord, direction and fillBit, then go to LOAD.
- State LOAD (exactly 1 cycle):
  - ParallelLoad = 1, Data = latched word, ready = 0.
  - Next state SHIFT, count cleared to 0.
- State SHIFT (exactly WIDTH cycles):
  - ParallelLoad = 0; ShiftLeft = ~dir and ShiftRight = dir, so both are never 1 together; ShiftInput = latched fill.
  - Each edge samples ShiftOutput:
    - dir = 0: capture <= {capture[WIDTH-2:0], ShiftOutput};
    - dir = 1: capture <= {ShiftOutput, capture[WIDTH-1:1]}.
  - count increments each edge; on the edge where count = WIDTH-1, go to DONE.
- State DONE (1 cycle):
  - done = 1, capturedWord = capture (updated on the edge entering DONE), ready = 0.
  - Next state IDLE.
- Latency: start accepted at edge k -> ParallelLoad high in cycle k..k+1 -> shifts in cycles k+1..k+WIDTH+1 -> done high in cycle k+WIDTH+1..k+WIDTH+2. Start-to-done = WIDTH+1 edges.
- Round trip: for the matching register, capturedWord equals loadWord in both directions.
- startRequest while ready = 0 (LOAD, SHIFT or DONE) is ignored and not queued.
- abort = 1 at an edge in LOAD or SHIFT:
  - next state IDLE, commands drop to 0, no done pulse;
  - capturedWord keeps its previous value; the partial capture is discarded.
- abort in IDLE or DONE has no effect.
- abort and startRequest together in IDLE: start is accepted.
- capturedWord holds until the next DONE or Reset.

Test Plan:
- Reset high for 1 cycle -> ready = 1, all commands 0, Data = 0, capturedWord = 0, done = 0.
- loadWord = 4'b1001, dir = 0, fill = 1, start 1 cycle, with a register model attached:
  - -> ParallelLoad 1 cycle with Data = 1001;
  - -> ShiftLeft 4 cycles with ShiftInput = 1;
  - -> done in the 6th cycle after accept, capturedWord = 1001, register = 1111.
- loadWord = 4'b0110, dir = 1, fill = 0:
  - -> ShiftRight 4 cycles, ShiftLeft never 1;
  - -> capturedWord = 0110, register = 0000.
- Start 1001 left, abort after 2 shift cycles:
  - -> commands 0 on the next edge, no done;
  - -> capturedWord still 0110, ready = 1.
- startRequest held high through a whole transfer:
  - -> exactly one transfer until DONE;
  - -> a new accept occurs only on the IDLE edge after done.
- Reset asserted mid-SHIFT between clock edges:
  - -> ShiftLeft/ShiftRight drop immediately, ready = 1, capturedWord = 0.
